// File: rtl/flag_byte_pkg.sv
// Shared types and constants for the flag-byte decoder.
// Optional feature macro: FLAG_BYTE_TIMEOUT_EN (idle timeout in HIGH_RCVD).
package flag_byte_pkg;

   typedef enum logic {
      IDLE      = 1'b0,
      HIGH_RCVD = 1'b1
   } state_t;

   localparam int FLAG_BIT       = 7;
   localparam int PAYLOAD_W      = 7;
   localparam int WORD_W         = 14;
   localparam int TIMEOUT_CYCLES = 15;

   // Timer width sized to hold TIMEOUT_CYCLES as a down-counter load value.
   localparam int                 TIMER_W      = 4;
   localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TIMEOUT_CYCLES);

   // Joins the held high payload and the incoming low payload.
   function automatic logic [WORD_W-1:0] pack_word(input logic [PAYLOAD_W-1:0] hi,
                                                   input logic [PAYLOAD_W-1:0] lo);
      return {hi, lo};
   endfunction

endpackage

// File: rtl/flag_byte_timeout.sv
// Idle timeout for the HIGH_RCVD state: a down-counter reloaded on every
// restart, decremented on each idle cycle, expiring on terminal count.
// Only instantiated when FLAG_BYTE_TIMEOUT_EN is defined.
module flag_byte_timeout
   import flag_byte_pkg::*;
(
   input  logic clk,
   input  logic clear,
   input  logic restart,
   input  logic run,
   output logic expired
);

   logic [TIMER_W-1:0] cnt;

   // Expiry fires on the idle cycle that would take the count from 1 to 0,
   // i.e. the TIMEOUT_CYCLES-th consecutive idle cycle after a reload.
   assign expired = run && (cnt == TIMER_W'(1));

   // Reload on restart, count down while idle in HIGH_RCVD, stop at zero.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         cnt <= '0;
      end else if (restart) begin
         cnt <= TIMEOUT_LOAD;
      end else if (run && (cnt != '0)) begin
         cnt <= cnt - TIMER_W'(1);
      end
   end

endmodule

// File: rtl/flag_byte_decoder.sv
// Two-byte frame decoder: a flagged byte carries the high payload, the
// following unflagged byte carries the low payload and completes the frame.
// Optional feature macro: FLAG_BYTE_TIMEOUT_EN (abandon a half frame after
// TIMEOUT_CYCLES idle cycles).
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   IDLE      | waiting for a flagged (high) byte
//   HIGH_RCVD | high payload held, waiting for the unflagged low byte
module flag_byte_decoder
   import flag_byte_pkg::*;
(
   input  logic              clk,
   input  logic              clear,
   input  logic [7:0]        cct_input,
   input  logic              in_valid,
   output logic [WORD_W-1:0] cct_output,
   output logic              out_valid,
   output logic              frame_err,
   output logic [7:0]        frame_count
);

   state_t               state;
   logic [PAYLOAD_W-1:0] hold;
   logic                 flag;
   logic [PAYLOAD_W-1:0] payload;
   logic                 timeout_hit;

   assign flag    = cct_input[FLAG_BIT];
   assign payload = cct_input[PAYLOAD_W-1:0];

`ifdef FLAG_BYTE_TIMEOUT_EN
   logic tmo_restart;
   logic tmo_run;

   // Reload whenever a byte arrives (covers entry to HIGH_RCVD) and while idle.
   assign tmo_restart = in_valid || (state != HIGH_RCVD);
   assign tmo_run     = !in_valid && (state == HIGH_RCVD);

   flag_byte_timeout u_timeout (
      .clk     (clk),
      .clear   (clear),
      .restart (tmo_restart),
      .run     (tmo_run),
      .expired (timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   // Frame FSM with registered outputs; out_valid defaults low so it pulses.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state       <= IDLE;
         hold        <= '0;
         cct_output  <= '0;
         out_valid   <= 1'b0;
         frame_err   <= 1'b0;
         frame_count <= '0;
      end else begin
         out_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (flag) begin
                     hold  <= payload;
                     state <= HIGH_RCVD;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
            end
            HIGH_RCVD: begin
               if (in_valid) begin
                  if (!flag) begin
                     cct_output  <= pack_word(hold, payload);
                     out_valid   <= 1'b1;
                     frame_count <= frame_count + 8'd1;
                     state       <= IDLE;
                  end else begin
                     // A second high byte restarts the frame with the newer payload.
                     frame_err <= 1'b1;
                     hold      <= payload;
                  end
               end else if (timeout_hit) begin
                  frame_err <= 1'b1;
                  state     <= IDLE;
               end
            end
         endcase
      end
   end

endmodule
